// File: rtl/prim_fifo_async_pkg.sv
// Shared helpers for asynchronous FIFOs whose depth need not be a power of two.
//
// A FIFO pointer is a value field of ptrv_w bits (counting 0..depth-1) with a
// lap bit directly above it. These functions work on a 32-bit container so
// that one definition serves every Depth. Callers pass Depth and the value
// width, then truncate the result to their own pointer width.
//
// Crossing encoding (reflected Gray code):
//   lap 0 : gray(v)              with the lap bit clear
//   lap 1 : gray(depth - 1 - v)  with the lap bit set
// Exactly one bit changes per increment, including both wrap points.
package prim_fifo_async_pkg;

  localparam int unsigned MaxPtrW = 32;

  typedef logic [MaxPtrW-1:0] ptr_t;

  function automatic ptr_t val_mask(input int unsigned ptrv_w);
    return (ptr_t'(1) << ptrv_w) - ptr_t'(1);
  endfunction

  function automatic ptr_t lap_mask(input int unsigned ptrv_w);
    return ptr_t'(1) << ptrv_w;
  endfunction

  // Binary pointer increment: the value wraps depth-1 -> 0 and the lap bit toggles.
  function automatic ptr_t ptr_inc(input int unsigned depth, input int unsigned ptrv_w,
                                   input ptr_t ptr);
    ptr_t v;
    v = ptr & val_mask(ptrv_w);
    if (v == ptr_t'(depth - 1)) begin
      return (ptr & lap_mask(ptrv_w)) ^ lap_mask(ptrv_w);
    end
    return ptr + ptr_t'(1);
  endfunction

  function automatic ptr_t dec2gray(input int unsigned depth, input int unsigned ptrv_w,
                                    input ptr_t ptr);
    ptr_t v;
    ptr_t g;
    logic lap;
    lap = |(ptr & lap_mask(ptrv_w));
    v   = ptr & val_mask(ptrv_w);
    if (lap) begin
      v = ptr_t'(depth) - ptr_t'(1) - v;
    end
    g = v ^ (v >> 1);
    return g | (ptr_t'(lap) << ptrv_w);
  endfunction

  function automatic ptr_t gray2dec(input int unsigned depth, input int unsigned ptrv_w,
                                    input ptr_t gray);
    ptr_t g;
    ptr_t b;
    logic lap;
    lap = |(gray & lap_mask(ptrv_w));
    g   = gray & val_mask(ptrv_w);
    b   = g;
    // Each binary bit is the XOR of all Gray bits at or above it.
    for (int unsigned i = 1; i < MaxPtrW; i++) begin
      b = b ^ (g >> i);
    end
    if (lap) begin
      b = ptr_t'(depth) - ptr_t'(1) - b;
    end
    return b | (ptr_t'(lap) << ptrv_w);
  endfunction

  // Entry count between a leading and a trailing binary pointer. When the lap
  // bits differ the leader has wrapped once more, which also covers the full
  // case (equal values, different laps -> depth).
  function automatic int unsigned depth_diff(input int unsigned depth, input int unsigned ptrv_w,
                                             input ptr_t lead, input ptr_t trail);
    ptr_t lv;
    ptr_t tv;
    lv = lead & val_mask(ptrv_w);
    tv = trail & val_mask(ptrv_w);
    if (((lead ^ trail) & lap_mask(ptrv_w)) == '0) begin
      return int'(lv - tv);
    end
    return depth - int'(tv) + int'(lv);
  endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for multi-bit values that change at most one bit at a
// time (Gray-coded pointers).
//   clk_i / rst_ni : destination clock and asynchronous active-low reset
//   d_i            : value from the source domain, already registered there
//   q_o            : value synchronised into the destination domain
module prim_flop_2sync #(
  parameter int unsigned       Width      = 1,
  parameter logic [Width-1:0]  ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      q_o    <= ResetValue;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/prim_fifo_async_thr.sv
// Asynchronous FIFO with occupancy, almost-full / almost-empty thresholds and
// sticky overflow / underflow flags. Depth may be any integer >= 3.
//
// Write domain (clk_wr_i, rst_wr_ni):
//   wvalid/wready/wdata : write handshake; a write while full is dropped and sets wovf
//   wdepth, walmost_full: occupancy as seen from the write side
//   wovf, wovf_clr      : sticky overflow flag and its clear
// Read domain (clk_rd_i, rst_rd_ni):
//   rvalid/rready/rdata : first-word fall-through read handshake
//   rdepth, ralmost_empty: occupancy as seen from the read side
//   rudf, rudf_clr      : sticky underflow flag and its clear
//
// Storage is not reset. Assert both resets together to restart the FIFO;
// resetting only one domain while data is in flight is not supported.
module prim_fifo_async_thr
  import prim_fifo_async_pkg::*;
#(
  parameter int unsigned  Width          = 16,
  parameter int unsigned  Depth          = 5,
  parameter int unsigned  AlmostFullThr  = Depth - 1,
  parameter int unsigned  AlmostEmptyThr = 1,
  parameter bit           ZeroWhenEmpty  = 1'b0,
  localparam int unsigned DepthW         = $clog2(Depth + 1)
) (
  input  logic              clk_wr_i,
  input  logic              rst_wr_ni,
  input  logic              wvalid,
  output logic              wready,
  input  logic [Width-1:0]  wdata,
  output logic [DepthW-1:0] wdepth,
  output logic              walmost_full,
  output logic              wovf,
  input  logic              wovf_clr,

  input  logic              clk_rd_i,
  input  logic              rst_rd_ni,
  output logic              rvalid,
  input  logic              rready,
  output logic [Width-1:0]  rdata,
  output logic [DepthW-1:0] rdepth,
  output logic              ralmost_empty,
  output logic              rudf,
  input  logic              rudf_clr
);

  localparam int unsigned PtrVW = $clog2(Depth);
  localparam int unsigned PtrW  = PtrVW + 1;

  typedef logic [PtrW-1:0] fptr_t;

  if (Depth < 3) begin : gen_depth_chk
    $error("prim_fifo_async_thr: Depth must be at least 3");
  end
  if (AlmostFullThr < 1 || AlmostFullThr > Depth) begin : gen_afthr_chk
    $error("prim_fifo_async_thr: AlmostFullThr must be in 1..Depth");
  end
  if (AlmostEmptyThr > Depth - 1) begin : gen_aethr_chk
    $error("prim_fifo_async_thr: AlmostEmptyThr must be in 0..Depth-1");
  end

  logic [Width-1:0] mem [Depth];

  // ---------------------------------------------------------------- write side
  fptr_t wptr_q, wptr_gray_q, wptr_inc;
  fptr_t rptr_gray_wsync, rptr_wdec;
  logic  wfull, wpush;

  assign wptr_inc  = fptr_t'(ptr_inc(Depth, PtrVW, ptr_t'(wptr_q)));
  assign rptr_wdec = fptr_t'(gray2dec(Depth, PtrVW, ptr_t'(rptr_gray_wsync)));
  assign wfull     = (wptr_q == {~rptr_wdec[PtrW-1], rptr_wdec[PtrVW-1:0]});
  assign wready    = ~wfull;
  assign wpush     = wvalid & wready;

  // The Gray copy is registered alongside the binary pointer so the
  // synchroniser only ever sees a flop output with a single toggling bit.
  always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
    if (!rst_wr_ni) begin
      wptr_q      <= '0;
      wptr_gray_q <= '0;
    end else if (wpush) begin
      wptr_q      <= wptr_inc;
      wptr_gray_q <= fptr_t'(dec2gray(Depth, PtrVW, ptr_t'(wptr_inc)));
    end
  end

  // A new overflow on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
    if (!rst_wr_ni) begin
      wovf <= 1'b0;
    end else if (wvalid && !wready) begin
      wovf <= 1'b1;
    end else if (wovf_clr) begin
      wovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_wr_i) begin
    if (wpush) begin
      mem[wptr_q[PtrVW-1:0]] <= wdata;
    end
  end

  assign wdepth       = DepthW'(depth_diff(Depth, PtrVW, ptr_t'(wptr_q), ptr_t'(rptr_wdec)));
  assign walmost_full = (32'(wdepth) >= AlmostFullThr);

  // ----------------------------------------------------------------- read side
  fptr_t rptr_q, rptr_gray_q, rptr_inc;
  fptr_t wptr_gray_rsync, wptr_rdec;
  logic  rpop;
  logic [Width-1:0] rdata_raw;

  assign rptr_inc  = fptr_t'(ptr_inc(Depth, PtrVW, ptr_t'(rptr_q)));
  assign wptr_rdec = fptr_t'(gray2dec(Depth, PtrVW, ptr_t'(wptr_gray_rsync)));
  assign rvalid    = (rptr_q != wptr_rdec);
  assign rpop      = rvalid & rready;

  always_ff @(posedge clk_rd_i or negedge rst_rd_ni) begin
    if (!rst_rd_ni) begin
      rptr_q      <= '0;
      rptr_gray_q <= '0;
    end else if (rpop) begin
      rptr_q      <= rptr_inc;
      rptr_gray_q <= fptr_t'(dec2gray(Depth, PtrVW, ptr_t'(rptr_inc)));
    end
  end

  always_ff @(posedge clk_rd_i or negedge rst_rd_ni) begin
    if (!rst_rd_ni) begin
      rudf <= 1'b0;
    end else if (rready && !rvalid) begin
      rudf <= 1'b1;
    end else if (rudf_clr) begin
      rudf <= 1'b0;
    end
  end

  assign rdata_raw     = mem[rptr_q[PtrVW-1:0]];
  assign rdata         = (ZeroWhenEmpty && !rvalid) ? '0 : rdata_raw;
  assign rdepth        = DepthW'(depth_diff(Depth, PtrVW, ptr_t'(wptr_rdec), ptr_t'(rptr_q)));
  assign ralmost_empty = (32'(rdepth) <= AlmostEmptyThr);

  // ------------------------------------------------------------ synchronisers
  prim_flop_2sync #(
    .Width (PtrW)
  ) u_sync_wptr (
    .clk_i  (clk_rd_i),
    .rst_ni (rst_rd_ni),
    .d_i    (wptr_gray_q),
    .q_o    (wptr_gray_rsync)
  );

  prim_flop_2sync #(
    .Width (PtrW)
  ) u_sync_rptr (
    .clk_i  (clk_wr_i),
    .rst_ni (rst_wr_ni),
    .d_i    (rptr_gray_q),
    .q_o    (rptr_gray_wsync)
  );

endmodule

// File: tb/tb_prim_fifo_async_thr.sv
// Self-checking bench for prim_fifo_async_thr (Width=8, Depth=5,
// AlmostFullThr=4, AlmostEmptyThr=1) plus a ZeroWhenEmpty=1 instance.
module tb_prim_fifo_async_thr;

  localparam int DEPTH = 5;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  typedef enum logic [2:0] {OP_IDLE, OP_WR, OP_RD, OP_OCLR, OP_UCLR} op_e;

  typedef struct {
    op_e        op;
    logic [7:0] data;
    int         wdepth;
    bit         wready;
    bit         waf;
    bit         wovf;
    int         rdepth;
    bit         rvalid;
    bit         rae;
    bit         rudf;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int checks = 0;
  int passes = 0;

  logic [7:0] sb[$];
  int         mcount = 0;

  int wr_hi = 5, wr_lo = 5, rd_hi = 11, rd_lo = 12;

  logic       clk_wr, clk_rd, rst_wr_n, rst_rd_n;
  logic       wvalid, wready, wovf, wovf_clr, walmost_full;
  logic [7:0] wdata, rdata;
  logic [2:0] wdepth, rdepth;
  logic       rvalid, rready, ralmost_empty, rudf, rudf_clr;

  logic       wvalid_z, wready_z, wovf_z, walmost_full_z;
  logic [7:0] wdata_z, rdata_z;
  logic [2:0] wdepth_z, rdepth_z;
  logic       rvalid_z, ralmost_empty_z, rudf_z;

  prim_fifo_async_thr #(
    .Width(8), .Depth(5), .AlmostFullThr(4), .AlmostEmptyThr(1), .ZeroWhenEmpty(1'b0)
  ) dut (
    .clk_wr_i(clk_wr), .rst_wr_ni(rst_wr_n), .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wdepth(wdepth), .walmost_full(walmost_full), .wovf(wovf),
    .wovf_clr(wovf_clr), .clk_rd_i(clk_rd), .rst_rd_ni(rst_rd_n), .rvalid(rvalid),
    .rready(rready), .rdata(rdata), .rdepth(rdepth), .ralmost_empty(ralmost_empty),
    .rudf(rudf), .rudf_clr(rudf_clr)
  );

  prim_fifo_async_thr #(
    .Width(8), .Depth(5), .AlmostFullThr(4), .AlmostEmptyThr(1), .ZeroWhenEmpty(1'b1)
  ) dut_z (
    .clk_wr_i(clk_wr), .rst_wr_ni(rst_wr_n), .wvalid(wvalid_z), .wready(wready_z),
    .wdata(wdata_z), .wdepth(wdepth_z), .walmost_full(walmost_full_z), .wovf(wovf_z),
    .wovf_clr(1'b0), .clk_rd_i(clk_rd), .rst_rd_ni(rst_rd_n), .rvalid(rvalid_z),
    .rready(1'b0), .rdata(rdata_z), .rdepth(rdepth_z), .ralmost_empty(ralmost_empty_z),
    .rudf(rudf_z), .rudf_clr(1'b0)
  );

  initial begin
    clk_wr = 1'b0;
    forever begin
      #(wr_lo) clk_wr = 1'b1;
      #(wr_hi) clk_wr = 1'b0;
    end
  end

  initial begin
    clk_rd = 1'b0;
    forever begin
      #(rd_lo) clk_rd = 1'b1;
      #(rd_hi) clk_rd = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", passes, checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Every registered Gray pointer change must flip exactly one bit.
  initial begin
    logic [3:0] prev;
    prev = '0;
    forever begin
      @(negedge clk_wr);
      if (dut.wptr_gray_q !== prev) begin
        chk("wptr_gray_step", 32'($countones(dut.wptr_gray_q ^ prev)), 32'd1);
        prev = dut.wptr_gray_q;
      end
    end
  end

  initial begin
    logic [3:0] prev;
    prev = '0;
    forever begin
      @(negedge clk_rd);
      if (dut.rptr_gray_q !== prev) begin
        chk("rptr_gray_step", 32'($countones(dut.rptr_gray_q ^ prev)), 32'd1);
        prev = dut.rptr_gray_q;
      end
    end
  end

  task automatic settle();
    repeat (6) @(posedge clk_wr);
    repeat (6) @(posedge clk_rd);
    #1;
  endtask

  task automatic do_op(input op_e op, input logic [7:0] d);
    case (op)
      OP_WR: begin
        @(posedge clk_wr); #1;
        wvalid = 1'b1;
        wdata  = d;
        if (mcount < DEPTH) begin
          sb.push_back(d);
          mcount++;
        end
        @(posedge clk_wr); #1;
        wvalid = 1'b0;
      end
      OP_RD: begin
        @(posedge clk_rd); #1;
        if (mcount > 0) begin
          chk("rdata", 32'(rdata), 32'(sb.pop_front()));
          mcount--;
        end
        rready = 1'b1;
        @(posedge clk_rd); #1;
        rready = 1'b0;
      end
      OP_OCLR: begin
        @(posedge clk_wr); #1;
        wovf_clr = 1'b1;
        @(posedge clk_wr); #1;
        wovf_clr = 1'b0;
      end
      OP_UCLR: begin
        @(posedge clk_rd); #1;
        rudf_clr = 1'b1;
        @(posedge clk_rd); #1;
        rudf_clr = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d_wdepth", i), 32'(wdepth), 32'(v.wdepth));
    chk($sformatf("v%0d_wready", i), 32'(wready), 32'(v.wready));
    chk($sformatf("v%0d_walmost_full", i), 32'(walmost_full), 32'(v.waf));
    chk($sformatf("v%0d_wovf", i), 32'(wovf), 32'(v.wovf));
    chk($sformatf("v%0d_rdepth", i), 32'(rdepth), 32'(v.rdepth));
    chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(v.rvalid));
    chk($sformatf("v%0d_ralmost_empty", i), 32'(ralmost_empty), 32'(v.rae));
    chk($sformatf("v%0d_rudf", i), 32'(rudf), 32'(v.rudf));
  endtask

  task automatic stream_writer(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      logic [7:0] d;
      guard = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk_wr); #1; end
      while (!wready && guard < 2000) begin
        @(posedge clk_wr); #1;
        guard++;
      end
      if (guard >= 2000) begin
        chk("stream_wready_timeout", 32'(guard), 32'd0);
        break;
      end
      d = 8'($urandom_range(0, 255));
      wvalid = 1'b1;
      wdata  = d;
      sb.push_back(d);
      @(posedge clk_wr); #1;
      wvalid = 1'b0;
    end
  endtask

  task automatic stream_reader(input int n);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 20000) begin
      @(posedge clk_rd); #1;
      rready = 1'b0;
      cyc++;
      if (rvalid && $urandom_range(0, 3) != 0) begin
        if (sb.size() == 0) begin
          chk("stream_spurious_rvalid", 32'(sb.size()), 32'd1);
        end else begin
          chk("stream_rdata", 32'(rdata), 32'(sb.pop_front()));
        end
        rready = 1'b1;
        got++;
      end
    end
    @(posedge clk_rd); #1;
    rready = 1'b0;
    chk("stream_count", 32'(got), 32'(n));
  endtask

  initial begin
    int n;

    vecs[0]  = '{OP_IDLE, 8'h00, 0, H, L, L, 0, L, H, L};
    vecs[1]  = '{OP_WR,   8'h11, 1, H, L, L, 1, H, H, L};
    vecs[2]  = '{OP_WR,   8'h22, 2, H, L, L, 2, H, L, L};
    vecs[3]  = '{OP_WR,   8'h33, 3, H, L, L, 3, H, L, L};
    vecs[4]  = '{OP_WR,   8'h44, 4, H, H, L, 4, H, L, L};
    vecs[5]  = '{OP_WR,   8'h55, 5, L, H, L, 5, H, L, L};
    vecs[6]  = '{OP_WR,   8'h99, 5, L, H, H, 5, H, L, L};
    vecs[7]  = '{OP_OCLR, 8'h00, 5, L, H, L, 5, H, L, L};
    vecs[8]  = '{OP_RD,   8'h00, 4, H, H, L, 4, H, L, L};
    vecs[9]  = '{OP_RD,   8'h00, 3, H, L, L, 3, H, L, L};
    vecs[10] = '{OP_RD,   8'h00, 2, H, L, L, 2, H, L, L};
    vecs[11] = '{OP_RD,   8'h00, 1, H, L, L, 1, H, H, L};
    vecs[12] = '{OP_RD,   8'h00, 0, H, L, L, 0, L, H, L};
    vecs[13] = '{OP_RD,   8'h00, 0, H, L, L, 0, L, H, H};
    vecs[14] = '{OP_UCLR, 8'h00, 0, H, L, L, 0, L, H, L};
    vecs[15] = '{OP_WR,   8'hAA, 1, H, L, L, 1, H, H, L};
    vecs[16] = '{OP_RD,   8'h00, 0, H, L, L, 0, L, H, L};

    rst_wr_n = 1'b0; rst_rd_n = 1'b0;
    wvalid = 1'b0; wdata = '0; wovf_clr = 1'b0;
    rready = 1'b0; rudf_clr = 1'b0;
    wvalid_z = 1'b0; wdata_z = '0;
    repeat (3) @(posedge clk_rd);
    #1;
    rst_wr_n = 1'b1; rst_rd_n = 1'b1;
    settle();

    // ZeroWhenEmpty instance: zero while empty, data once valid.
    chk("zwe_empty_rvalid", 32'(rvalid_z), 32'd0);
    chk("zwe_empty_rdata", 32'(rdata_z), 32'h00);
    @(posedge clk_wr); #1;
    wvalid_z = 1'b1; wdata_z = 8'hA5;
    @(posedge clk_wr); #1;
    wvalid_z = 1'b0;
    settle();
    chk("zwe_rvalid", 32'(rvalid_z), 32'd1);
    chk("zwe_rdata", 32'(rdata_z), 32'hA5);

    for (int i = 0; i < NVEC; i++) begin
      do_op(vecs[i].op, vecs[i].data);
      settle();
      check_vec(i, vecs[i]);
    end

    // Write-to-rvalid latency on an empty FIFO.
    @(posedge clk_wr); #1;
    wvalid = 1'b1; wdata = 8'h5A;
    sb.push_back(8'h5A); mcount++;
    @(posedge clk_wr); #1;
    wvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 8) begin
      @(posedge clk_rd); #1;
      n++;
    end
    chk("lat_wr_to_rvalid_le3", 32'(n <= 3), 32'd1);
    do_op(OP_RD, 8'h00);
    settle();

    // Read-to-wready release latency on a full FIFO.
    for (int i = 0; i < DEPTH; i++) do_op(OP_WR, 8'(8'hC0 + i));
    settle();
    chk("full_wready", 32'(wready), 32'd0);
    @(posedge clk_rd); #1;
    chk("rdata", 32'(rdata), 32'(sb.pop_front()));
    mcount--;
    rready = 1'b1;
    @(posedge clk_rd); #1;
    rready = 1'b0;
    n = 0;
    while (!wready && n < 8) begin
      @(posedge clk_wr); #1;
      n++;
    end
    chk("lat_rd_to_wready_le4", 32'(n <= 4), 32'd1);
    for (int i = 0; i < DEPTH - 1; i++) do_op(OP_RD, 8'h00);
    settle();
    chk("drained_rdepth", 32'(rdepth), 32'd0);
    chk("drained_wdepth", 32'(wdepth), 32'd0);

    // Random streaming, then with the clock periods swapped.
    fork
      stream_writer(100);
      stream_reader(100);
    join
    settle();
    wr_hi = 11; wr_lo = 12; rd_hi = 5; rd_lo = 5;
    settle();
    fork
      stream_writer(100);
      stream_reader(100);
    join
    settle();

    chk("end_sb_empty", 32'(sb.size()), 32'd0);
    chk("end_rvalid", 32'(rvalid), 32'd0);
    chk("end_rdepth", 32'(rdepth), 32'd0);
    chk("end_wdepth", 32'(wdepth), 32'd0);
    chk("end_wovf", 32'(wovf), 32'd0);
    chk("end_rudf", 32'(rudf), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
